// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU slice control codes and bit-serial sequencer state encoding
package alu_ctrl_pkg;
  localparam logic [2:0] CTR_AND = 3'b000;
  localparam logic [2:0] CTR_OR  = 3'b001;
  localparam logic [2:0] CTR_ADD = 3'b010;
  localparam logic [2:0] CTR_XOR = 3'b011;
  localparam logic [2:0] CTR_SUB = 3'b110;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic logic is_sum(input logic [2:0] ctr);
    return ctr[1:0] == CTR_ADD[1:0];
  endfunction
endpackage

// File: rtl/alu_serial_dp.sv
// alu_serial_dp: operand/result shift registers, carry flop and bit counter for the serial ALU
module alu_serial_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       ctr_i,
  input  logic             slice_res_i,
  input  logic             slice_cout_i,
  output logic             a_bit_o,
  output logic             b_bit_o,
  output logic             carry_o,
  output logic [2:0]       ctr_o,
  output logic             last_o,
  output logic [WIDTH-1:0] res_d_o
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, res_sh_d;
  logic [2:0]       ctr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  assign res_sh_d = {slice_res_i, res_sh_q[WIDTH-1:1]};
  assign a_bit_o  = a_sh_q[0];
  assign b_bit_o  = b_sh_q[0];
  assign carry_o  = carry_q;
  assign ctr_o    = ctr_q;
  assign last_o   = cnt_q == CNT_W'(WIDTH - 1);
  assign res_d_o  = res_sh_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      ctr_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      a_sh_q  <= a_i;
      b_sh_q  <= b_i;
      ctr_q   <= ctr_i;
      carry_q <= ctr_i[2];
      cnt_q   <= '0;
    end else if (step_i) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= res_sh_d;
      carry_q  <= slice_cout_i;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: drives a shared 1-bit ALU slice for WIDTH cycles, LSB first, and returns result+flags
module alu_serial_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       ctr_in,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_ctr,
  input  logic             slice_res,
  input  logic             slice_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  state_t           state_q;
  logic             accept, run, last, a_bit, b_bit, carry;
  logic [2:0]       ctr;
  logic [WIDTH-1:0] res_d;
  assign accept = (state_q == S_IDLE) && op_valid;
  assign run    = state_q == S_RUN;
  alu_serial_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .load_i       (accept),
    .step_i       (run),
    .a_i          (a_in),
    .b_i          (b_in),
    .ctr_i        (ctr_in),
    .slice_res_i  (slice_res),
    .slice_cout_i (slice_cout),
    .a_bit_o      (a_bit),
    .b_bit_o      (b_bit),
    .carry_o      (carry),
    .ctr_o        (ctr),
    .last_o       (last),
    .res_d_o      (res_d)
  );
  // The slice is shared, so it sees all-zero stimulus whenever we are not computing.
  assign slice_a   = run & a_bit;
  assign slice_b   = run & b_bit;
  assign slice_cin = run & carry;
  assign slice_ctr = run ? ctr : 3'b000;
  assign zero      = ~|res_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_out   <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (op_valid) begin
          state_q  <= S_RUN;
          op_ready <= 1'b0;
        end
        S_RUN: if (last) begin
          state_q   <= S_DONE;
          res_valid <= 1'b1;
          res_out   <= res_d;
          c_out     <= slice_cout;
          ovf       <= is_sum(ctr) & (carry ^ slice_cout);
        end
        S_DONE: if (res_ready) begin
          state_q   <= S_IDLE;
          res_valid <= 1'b0;
          op_ready  <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          op_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
